// File: rtl/texture_loader.sv
// texture_loader: write-side front end for the texture memory.
// Takes a load command (base address, word count), then streams texel words
// over valid/ready and drives the memory write port with sequential addresses.
// Optional feature macro: TEXTURE_LOADER_BOUNDS_CHECK_EN rejects commands that
// would run past the end of memory. Without it, addresses wrap at MEM_DEPTH.
module texture_loader #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 107120
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic              r_in_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_write_address;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  logic              w_accept;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_bounds_err;

`ifdef TEXTURE_LOADER_BOUNDS_CHECK_EN
  localparam bit                BOUNDS_EN = 1'b1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(MEM_DEPTH);
  logic [ADDR_W:0] w_end_addr;
  // One extra bit so base+count cannot overflow before the comparison.
  assign w_end_addr   = {1'b0, base_addr} + {1'b0, word_count};
  assign w_bounds_err = (w_end_addr > DEPTH_X) || ({1'b0, base_addr} >= DEPTH_X);
`else
  localparam bit BOUNDS_EN = 1'b0;
  assign w_bounds_err = 1'b0;
`endif

  // in_ready is registered and is high exactly while in LOAD.
  assign w_accept    = in_valid && r_in_ready;
  // Address wraps at the end of physical memory, not at 2^ADDR_W.
  assign w_next_addr = (r_cur_addr == LAST_ADDR) ? '0 : r_cur_addr + 1'b1;

  // Command FSM with all status and write-port outputs registered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= S_IDLE;
      r_cur_addr      <= '0;
      r_remaining     <= '0;
      r_in_ready      <= 1'b0;
      r_we            <= 1'b0;
      r_write_address <= '0;
      r_data          <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur_addr  <= base_addr;
            r_remaining <= word_count;
            r_busy      <= 1'b1;
            if (word_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_bounds_err) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else begin
              r_state    <= S_LOAD;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_we            <= 1'b1;
            r_write_address <= r_cur_addr;
            r_data          <= in_data;
            r_cur_addr      <= w_next_addr;
            r_remaining     <= r_remaining - 1'b1;
            if (r_remaining == ADDR_W'(1)) begin
              r_state    <= S_FLUSH;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          // Last write is on the port this cycle; report completion next.
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign we            = r_we;
  assign write_address = r_write_address;
  assign data          = r_data;
  assign busy          = r_busy;
  assign done          = r_done;
  // ERR is unreachable without the bounds check, so error is a constant 0 there.
  assign error         = BOUNDS_EN ? r_error : 1'b0;

endmodule

// File: tb/tb_texture_loader.sv
// Scoreboard bench for texture_loader: the stimulus side pushes expected
// (address, data) writes; a monitor pops and compares on every we.
module tb_texture_loader;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 107120;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] word_count = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, we, busy, done, error;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] data;

  texture_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .we(we), .write_address(write_address), .data(data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write on the port must match the next expected write.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none", write_address, data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(write_address), 64'(mon_e.a));
        chk("wr_data", 64'(data), 64'(mon_e.d));
      end
    end
  end

  // mode: 0 = in_valid held high, 1 = toggling, 2 = random.
  task automatic run_cmd(input int base, input int cnt, input int mode,
                         input bit inject, input int abort_after);
    logic [DATA_W-1:0] words[$];
    bit exp_err;
    bit acc;
    bit injected;
    int idx;
    int budget;
    exp_err  = 1'b0;
    injected = 1'b0;
`ifdef TEXTURE_LOADER_BOUNDS_CHECK_EN
    exp_err = (base >= DEPTH) || (base + cnt > DEPTH);
`endif
    if (cnt == 0) exp_err = 1'b0;
    $display("cmd base=%0d count=%0d mode=%0d inject=%0d abort_after=%0d expect_err=%0d",
             base, cnt, mode, inject, abort_after, exp_err);
    for (int i = 0; i < cnt; i++) begin
      words.push_back($urandom);
      if (!exp_err) exp_q.push_back('{a: ADDR_W'((base + i) % DEPTH), d: words[i]});
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = ADDR_W'(base); word_count = ADDR_W'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (cnt == 0 || exp_err) begin
      chk("imm_done", 64'(done), 64'(cnt == 0));
      chk("imm_error", 64'(error), 64'(exp_err));
      chk("imm_in_ready", 64'(in_ready), 64'd0);
      chk("imm_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("imm_busy_after", 64'(busy), 64'd0);
      chk("imm_done_after", 64'(done), 64'd0);
      return;
    end
    chk("load_busy", 64'(busy), 64'd1);
    idx = 0;
    budget = 0;
    while (idx < cnt && budget < 1000) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (budget % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = words[idx];
      chk("load_in_ready", 64'(in_ready), 64'd1);
      if (inject && idx == 1 && !injected) begin
        injected   = 1'b1;
        start      = 1'b1;
        base_addr  = ADDR_W'(base ^ 'h40);
        word_count = ADDR_W'(3);
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) idx++;
      if (abort_after > 0 && idx == abort_after) begin
        #1 n_rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_addr", 64'(write_address), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 n_rst = 1'b1;
        return;
      end
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0;
    if (idx < cnt) begin
      checks++;
      errors++;
      $display("FAIL load_timeout actual=%0d required=%0d", idx, cnt);
      return;
    end
    // Now in the cycle after the final accept (FLUSH).
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    chk("all_written", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_we", 64'(we), 64'd0);
    chk("reset_addr", 64'(write_address), 64'd0);
    chk("reset_data", 64'(data), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    @(posedge clk); #1 n_rst = 1'b1;

    run_cmd('h10, 4, 0, 1'b0, 0);
    run_cmd('h10, 4, 1, 1'b0, 0);
    run_cmd('h20, 0, 0, 1'b0, 0);
    run_cmd(107118, 4, 0, 1'b0, 0);
    run_cmd('h30, 5, 0, 1'b0, 2);
    run_cmd('h100, 1, 0, 1'b0, 0);
    run_cmd('h200, 6, 0, 1'b1, 0);
    for (int r = 0; r < 8; r++) begin
      run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 12)), 2, 1'b0, 0);
    end
    run_cmd(DEPTH - 3, 3, 0, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
